fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the RV32I 5-stage pipeline. Holds the program counter, addresses instruction memory, and registers the fetched word into the decode stage. Its `op_d` output drives the main decoder's opcode input. It supports hazard-unit stalls, branch/jump redirect from Execute, and decode flush with NOP bubble insertion.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. Must be word-aligned.
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): word placed in decode on reset or flush.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall_f`  in  1  hold the PC (hazard unit).
- `stall_d`  in  1  hold the IF/ID register (hazard unit).
- `flush_d`  in  1  replace the IF/ID contents with a bubble.
- `pc_src_e`  in  1  taken branch/jump redirect from Execute.
- `pc_target_e`  in  32  redirect target from Execute.
- `imem_addr`  out  32  instruction memory address; equals `pc_f`, combinational.
- `imem_rdata`  in  32  instruction word; combinational read of `imem_addr`, valid in the same cycle.
- `pc_f`  out  32  current fetch PC.
- `instr_d`  out  32  registered instruction.
- `op_d`  out  7  `instr_d[6:0]`, feeds the main decoder.
- `pc_d`  out  32  PC of `instr_d`.
- `pc_plus4_d`  out  32  `pc_d + 4`.
- `valid_d`  out  1  `instr_d` is a real instruction, not a bubble.
- `fetch_cnt`  out  32  count of valid instructions loaded into decode.

## Operation
PC register:
- Reset: `pc_f <= RESET_PC`.
- Else if `pc_src_e`: `pc_f <= {pc_target_e[31:2], 2'b00}`. Redirect overrides `stall_f`.
- Else if `stall_f`: hold.
- Else: `pc_f <= pc_f + 4`. Modulo 2^32, so 32'hFFFF_FFFC wraps to 0.

IF/ID register (`instr_d`, `pc_d`, `pc_plus4_d`, `valid_d`), by priority:
1. `reset`: `instr_d=NOP_INSTR`, `pc_d=0`, `pc_plus4_d=0`, `valid_d=0`.
2. `flush_d`: same values as reset. Flush overrides `stall_d`.
3. `stall_d`: hold all fields.
4. Otherwise: `instr_d<=imem_rdata`, `pc_d<=pc_f`, `pc_plus4_d<=pc_f+4` (wrapping), `valid_d<=1`.

Counter:
- `fetch_cnt` resets to 0.
- It increments by 1 on each edge where case 4 applies. It wraps at 2^32.
- It does not increment on stall, flush or reset.

Further rules:
- `op_d` is always `instr_d[6:0]`. After reset or flush it is 7'b0010011, which the decoder treats as I-type ALU writing x0, so the bubble is harmless.
- `flush_d` and `pc_src_e` are normally asserted together by the hazard unit. The block does not enforce this pairing.
- Reset asserted mid-operation takes effect at the next edge and discards any pending redirect.

## Timing
- Fetch-to-decode latency is 1 cycle: the word at `pc_f` in cycle N appears on `instr_d` in cycle N+1.
- First edge with `reset` low: `instr_d` = mem[`RESET_PC`], `valid_d`=1, `pc_f`=`RESET_PC`+4.
- Redirect: `pc_src_e` high at edge N gives `pc_f`=target after N. The target instruction reaches `instr_d` after edge N+1.
- Stall: with `stall_f`=`stall_d`=1 for k cycles, all registered outputs hold for k cycles, then resume with no lost or duplicated instruction.
- `imem_addr` has no register stage. Memory read must complete within the cycle.

## Test plan
- Reset release with mem[0]=32'h0020_8033 and mem[4]=32'h0050_0093: after edge 1, `instr_d`=32'h0020_8033, `op_d`=7'b0110011, `pc_d`=0, `valid_d`=1. After edge 2, `instr_d`=32'h0050_0093, `pc_d`=4, `pc_plus4_d`=8, `fetch_cnt`=2.
- Stall `stall_f`=`stall_d`=1 for 3 cycles at `pc_f`=8: `pc_f` stays 8, `instr_d`/`pc_d` hold, `fetch_cnt` unchanged. After release the sequence continues at 8, 12.
- Redirect with `pc_src_e`=1, `flush_d`=1, `pc_target_e`=32'h40 and `stall_f`=1 in the same cycle: `pc_f`=32'h40, `instr_d`=32'h0000_0013, `valid_d`=0, `fetch_cnt` held. The next edge loads mem[0x40] with `pc_d`=32'h40.
- Misaligned target 32'h0000_0046: `pc_f` becomes 32'h0000_0044.
- Wrap: with `RESET_PC`=32'hFFFF_FFFC, after edge 1 `pc_d`=32'hFFFF_FFFC, `pc_plus4_d`=0, `pc_f`=0.
- Reset asserted mid-run with `pc_src_e`=1: next edge gives `pc_f`=`RESET_PC`, `valid_d`=0, `fetch_cnt`=0. The redirect is ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage with the IF/ID pipeline register.
// Holds the fetch PC, drives the instruction memory address combinationally,
// and registers the fetched word, its PC and PC+4 into the decode stage.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [6:0]  op_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [31:0] fetch_cnt
);

  logic [31:0] r_pc_f;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc_plus4_d;
  logic        r_valid_d;
  logic [31:0] r_fetch_cnt;

  logic [31:0] w_pc_plus4_f;
  logic [31:0] w_pc_next;
  logic        w_load_d;
  logic        w_unused_tgt_lsb;

  // The low two target bits are forced to zero, so they are never consumed.
  assign w_unused_tgt_lsb = &{1'b0, pc_target_e[1:0]};

  assign w_pc_plus4_f = r_pc_f + 32'd4;

  // A new instruction enters decode only when neither flushed nor stalled.
  assign w_load_d = ~flush_d & ~stall_d;

  // Next fetch PC: redirect beats stall, otherwise sequential (wrapping) fetch.
  always_comb begin
    w_pc_next = w_pc_plus4_f;
    if (pc_src_e) begin
      w_pc_next = {pc_target_e[31:2], 2'b00};
    end else if (stall_f) begin
      w_pc_next = r_pc_f;
    end
  end

  // PC register; reset discards any pending redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_f <= RESET_PC;
    end else begin
      r_pc_f <= w_pc_next;
    end
  end

  // IF/ID register: reset and flush insert a bubble, stall holds, else load.
  always_ff @(posedge clk) begin
    if (reset || flush_d) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= 32'd0;
      r_pc_plus4_d <= 32'd0;
      r_valid_d    <= 1'b0;
    end else if (!stall_d) begin
      r_instr_d    <= imem_rdata;
      r_pc_d       <= r_pc_f;
      r_pc_plus4_d <= w_pc_plus4_f;
      r_valid_d    <= 1'b1;
    end
  end

  // Count real instructions loaded into decode (wraps naturally at 2^32).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt <= 32'd0;
    end else if (w_load_d) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign imem_addr  = r_pc_f;
  assign pc_f       = r_pc_f;
  assign instr_d    = r_instr_d;
  assign op_d       = r_instr_d[6:0];
  assign pc_d       = r_pc_d;
  assign pc_plus4_d = r_pc_plus4_d;
  assign valid_d    = r_valid_d;
  assign fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus for fetch_stage with a behavioural
// pipeline model checked every cycle, plus hand-computed literal checks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e;

  logic [31:0] imem_addr, imem_rdata, pc_f, instr_d, pc_d, pc_plus4_d, fetch_cnt;
  logic [6:0]  op_d;
  logic        valid_d;

  logic [31:0] w2_imem_addr, w2_imem_rdata, w2_pc_f, w2_instr_d, w2_pc_d, w2_pc_plus4_d, w2_fetch_cnt;
  logic [6:0]  w2_op_d;
  logic        w2_valid_d;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata    = mem[imem_addr[9:2]];
  assign w2_imem_rdata = mem[w2_imem_addr[9:2]];

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc_f(pc_f),
    .instr_d(instr_d), .op_d(op_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .fetch_cnt(fetch_cnt)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .imem_addr(w2_imem_addr), .imem_rdata(w2_imem_rdata), .pc_f(w2_pc_f),
    .instr_d(w2_instr_d), .op_d(w2_op_d), .pc_d(w2_pc_d), .pc_plus4_d(w2_pc_plus4_d),
    .valid_d(w2_valid_d), .fetch_cnt(w2_fetch_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Behavioural model: a fetch pointer plus one decode slot.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } slot_t;

  logic [31:0] m_pc;
  slot_t       m_dec;
  logic [31:0] m_cnt;
  bit          m_init = 0;

  always @(posedge clk) begin
    slot_t fetched;
    fetched.instr = mem[m_pc[9:2]];
    fetched.pc    = m_pc;
    fetched.pc4   = m_pc + 32'd4;
    fetched.valid = 1'b1;
    if (reset) begin
      m_pc   = 32'h0;
      m_dec  = '{32'h13, 32'h0, 32'h0, 1'b0};
      m_cnt  = 0;
      m_init = 1;
    end else begin
      if (flush_d) m_dec = '{32'h13, 32'h0, 32'h0, 1'b0};
      else if (!stall_d) begin
        m_dec = fetched;
        m_cnt = m_cnt + 1;
      end
      if (pc_src_e)      m_pc = pc_target_e & 32'hFFFF_FFFC;
      else if (!stall_f) m_pc = m_pc + 32'd4;
    end
  end

  // Compare every cycle once the model has seen reset.
  always @(negedge clk) begin
    if (m_init) begin
      chk("pc_f",       pc_f,       m_pc);
      chk("imem_addr",  imem_addr,  m_pc);
      chk("instr_d",    instr_d,    m_dec.instr);
      chk("op_d",       {25'd0, op_d}, {25'd0, m_dec.instr[6:0]});
      chk("pc_d",       pc_d,       m_dec.pc);
      chk("pc_plus4_d", pc_plus4_d, m_dec.pc4);
      chk("valid_d",    {31'd0, valid_d}, {31'd0, m_dec.valid});
      chk("fetch_cnt",  fetch_cnt,  m_cnt);
    end
  end

  task automatic cyc(input logic rst, input logic sf, input logic sd, input logic fd,
                     input logic src, input logic [31:0] tgt, input string tag);
    reset = rst; stall_f = sf; stall_d = sd; flush_d = fd; pc_src_e = src; pc_target_e = tgt;
    @(posedge clk);
    #1;
    $display("cycle %-10s rst=%0b sf=%0b sd=%0b fd=%0b src=%0b tgt=%08h -> pc_f=%08h instr_d=%08h pc_d=%08h v=%0b cnt=%0d",
             tag, rst, sf, sd, fd, src, tgt, pc_f, instr_d, pc_d, valid_d, fetch_cnt);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = (i << 12) | 32'h33;
    mem[0]   = 32'h0020_8033;
    mem[1]   = 32'h0050_0093;
    mem[2]   = 32'h0000_1111;
    mem[3]   = 32'h0000_2233;
    mem[16]  = 32'h00A0_0113;
    mem[17]  = 32'h0000_3363;
    mem[255] = 32'h0FF0_0F13;

    cyc(1, 0, 0, 0, 0, 32'h0, "reset");
    cyc(1, 0, 0, 0, 0, 32'h0, "reset");
    chk("rst_valid", {31'd0, valid_d}, 32'd0);
    chk("rst_op",    {25'd0, op_d}, 32'h13);
    chk("rst_pcf",   pc_f, 32'h0);

    cyc(0, 0, 0, 0, 0, 32'h0, "run1");
    chk("e1_instr", instr_d, 32'h0020_8033);
    chk("e1_op",    {25'd0, op_d}, 32'h33);
    chk("e1_pcd",   pc_d, 32'h0);
    chk("e1_valid", {31'd0, valid_d}, 32'd1);
    chk("e1_pcf",   pc_f, 32'h4);
    chk("wrap_pcd", w2_pc_d, 32'hFFFF_FFFC);
    chk("wrap_p4",  w2_pc_plus4_d, 32'h0);
    chk("wrap_pcf", w2_pc_f, 32'h0);
    chk("wrap_ins", w2_instr_d, 32'h0FF0_0F13);

    cyc(0, 0, 0, 0, 0, 32'h0, "run2");
    chk("e2_instr", instr_d, 32'h0050_0093);
    chk("e2_pcd",   pc_d, 32'h4);
    chk("e2_p4",    pc_plus4_d, 32'h8);
    chk("e2_cnt",   fetch_cnt, 32'd2);

    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 1, 0, 0, 32'h0, "stall");
      chk("st_pcf", pc_f, 32'h8);
      chk("st_pcd", pc_d, 32'h4);
      chk("st_cnt", fetch_cnt, 32'd2);
    end
    cyc(0, 0, 0, 0, 0, 32'h0, "resume");
    chk("rs_pcd",   pc_d, 32'h8);
    chk("rs_instr", instr_d, 32'h0000_1111);
    cyc(0, 0, 0, 0, 0, 32'h0, "resume");
    chk("rs_pcd2",  pc_d, 32'hC);
    chk("rs_cnt",   fetch_cnt, 32'd4);

    cyc(0, 1, 0, 1, 1, 32'h40, "redirect");
    chk("rd_pcf",   pc_f, 32'h40);
    chk("rd_instr", instr_d, 32'h0000_0013);
    chk("rd_valid", {31'd0, valid_d}, 32'd0);
    chk("rd_cnt",   fetch_cnt, 32'd4);
    cyc(0, 0, 0, 0, 0, 32'h0, "target");
    chk("tg_instr", instr_d, 32'h00A0_0113);
    chk("tg_pcd",   pc_d, 32'h40);
    chk("tg_cnt",   fetch_cnt, 32'd5);

    cyc(0, 0, 0, 0, 1, 32'h46, "misalign");
    chk("ma_pcf", pc_f, 32'h44);
    cyc(0, 0, 0, 0, 0, 32'h0, "run");
    chk("ma_pcd", pc_d, 32'h44);

    cyc(0, 0, 1, 1, 0, 32'h0, "flush_sd");
    chk("fs_valid", {31'd0, valid_d}, 32'd0);
    cyc(0, 0, 1, 0, 0, 32'h0, "stall_d");
    cyc(0, 1, 0, 0, 0, 32'h0, "stall_f");
    cyc(0, 0, 0, 0, 0, 32'h0, "run");
    cyc(0, 0, 0, 0, 0, 32'h0, "run");

    cyc(1, 0, 0, 0, 1, 32'h80, "rst_redir");
    chk("mr_pcf",   pc_f, 32'h0);
    chk("mr_valid", {31'd0, valid_d}, 32'd0);
    chk("mr_cnt",   fetch_cnt, 32'd0);
    cyc(0, 0, 0, 0, 0, 32'h0, "run");
    chk("ar_instr", instr_d, 32'h0020_8033);
    cyc(0, 0, 0, 0, 0, 32'h0, "run");
    chk("ar_cnt",   fetch_cnt, 32'd2);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
